lcd_cmd_seq: RTL and testbench

Command sequencer downstream of the LCD command register bank. On `start` it walks the bank's 32 entries by driving `sel_out`, captures each registered `{Address_in, Control_in, Data_in}` triple, and turns it into one or two HD44780-style parallel bus cycles (`lcd_rs`/`lcd_rw`/`lcd_e`/`lcd_data`) with programmable setup, pulse, hold and inter-command gaps. It reports progress back to the bank's `status` input.

---
 rtl/lcd_pkg.sv | 33 +++
 rtl/lcd_cmd_seq_if.sv | 24 ++
 rtl/lcd_bus_cycle.sv | 93 +++++++++
 rtl/lcd_cmd_seq.sv | 172 +++++++++++++++++
 tb/tb_lcd_cmd_seq.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD command sequencer: control-byte bit
// positions, the DDRAM set-address opcode, and the FSM encodings.
package lcd_pkg;

   localparam int unsigned CTL_VALID    = 7;
   localparam int unsigned CTL_LAST     = 6;
   localparam int unsigned CTL_SET_ADDR = 5;
   localparam int unsigned CTL_RS       = 0;

   localparam logic [7:0] LCD_SET_DDRAM = 8'h80;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_ADDR_CYC,
      ST_DATA_CYC,
      ST_DONE
   } seq_state_t;

   typedef enum logic [2:0] {
      PH_IDLE,
      PH_SETUP,
      PH_PULSE,
      PH_HOLD,
      PH_GAP
   } bus_phase_t;

   // Set-DDRAM-address command byte for a 7-bit display address.
   function automatic logic [7:0] ddram_cmd(input logic [6:0] addr);
      return LCD_SET_DDRAM | {1'b0, addr};
   endfunction

endpackage

// File: rtl/lcd_cmd_seq_if.sv
// Register-bank and LCD parallel-bus signals of the command sequencer.
interface lcd_cmd_seq_if;

   logic [4:0] sel_out;
   logic [7:0] Address_in;
   logic [7:0] Control_in;
   logic [7:0] Data_in;
   logic [7:0] status;
   logic       lcd_rs;
   logic       lcd_rw;
   logic       lcd_e;
   logic [7:0] lcd_data;

   modport master (
      output sel_out, status, lcd_rs, lcd_rw, lcd_e, lcd_data,
      input  Address_in, Control_in, Data_in
   );

   modport slave (
      input  sel_out, status, lcd_rs, lcd_rw, lcd_e, lcd_data,
      output Address_in, Control_in, Data_in
   );

endinterface

// File: rtl/lcd_bus_cycle.sv
// One HD44780 bus cycle: SETUP, PULSE (E high), HOLD, GAP, on a shared counter.
// A new go is accepted while idle or in the final GAP cycle so cycles chain
// back-to-back.
module lcd_bus_cycle
   import lcd_pkg::*;
#(
   parameter int unsigned T_SETUP = 2,
   parameter int unsigned T_PULSE = 12,
   parameter int unsigned T_HOLD  = 2,
   parameter int unsigned T_GAP   = 2000,
   parameter int unsigned CNT_W   = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       go,
   input  logic       go_rs,
   input  logic [7:0] go_data,
   output logic       lcd_e,
   output logic       lcd_rs,
   output logic [7:0] lcd_data,
   output logic       idle,
   output logic       last
);

   localparam logic [CNT_W-1:0] SETUP_END = CNT_W'(T_SETUP - 1);
   localparam logic [CNT_W-1:0] PULSE_END = CNT_W'(T_PULSE - 1);
   localparam logic [CNT_W-1:0] HOLD_END  = CNT_W'(T_HOLD - 1);
   localparam logic [CNT_W-1:0] GAP_END   = CNT_W'(T_GAP - 1);

   bus_phase_t       phase, phase_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic             e_nx, rs_nx;
   logic [7:0]       data_nx;

   assign idle = (phase == PH_IDLE);
   assign last = (phase == PH_GAP) && (cnt == GAP_END);

   // Phase register and registered bus outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         phase    <= PH_IDLE;
         cnt      <= '0;
         lcd_e    <= 1'b0;
         lcd_rs   <= 1'b0;
         lcd_data <= '0;
      end else begin
         phase    <= phase_nx;
         cnt      <= cnt_nx;
         lcd_e    <= e_nx;
         lcd_rs   <= rs_nx;
         lcd_data <= data_nx;
      end
   end

   // Phase sequencing; rs/data only change when a new cycle is launched.
   always_comb begin
      phase_nx = phase;
      cnt_nx   = cnt + 1'b1;
      e_nx     = lcd_e;
      rs_nx    = lcd_rs;
      data_nx  = lcd_data;
      if (go && (idle || last)) begin
         phase_nx = PH_SETUP;
         cnt_nx   = '0;
         e_nx     = 1'b0;
         rs_nx    = go_rs;
         data_nx  = go_data;
      end else begin
         case (phase)
            PH_SETUP: if (cnt == SETUP_END) begin
               phase_nx = PH_PULSE;
               cnt_nx   = '0;
               e_nx     = 1'b1;
            end
            PH_PULSE: if (cnt == PULSE_END) begin
               phase_nx = PH_HOLD;
               cnt_nx   = '0;
               e_nx     = 1'b0;
            end
            PH_HOLD: if (cnt == HOLD_END) begin
               phase_nx = PH_GAP;
               cnt_nx   = '0;
            end
            PH_GAP: if (cnt == GAP_END) begin
               phase_nx = PH_IDLE;
               cnt_nx   = '0;
            end
            default: cnt_nx = '0;
         endcase
      end
   end

endmodule

// File: rtl/lcd_cmd_seq.sv
// LCD command sequencer: walks the 32-entry command bank, decodes each entry
// and hands one or two bus cycles to lcd_bus_cycle.
module lcd_cmd_seq
   import lcd_pkg::*;
#(
   parameter int unsigned T_SETUP = 2,
   parameter int unsigned T_PULSE = 12,
   parameter int unsigned T_HOLD  = 2,
   parameter int unsigned T_GAP   = 2000,
   parameter int unsigned CNT_W   = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   output logic          busy,
   output logic          done,
   lcd_cmd_seq_if.master bus
);

   seq_state_t state, state_nx;
   logic       fetch_ph, fetch_nx;
   logic       launched, launched_nx;
   logic [4:0] sel, sel_nx;
   logic       done_sticky, sticky_nx;
   logic [7:0] addr_cmd, addr_nx;
   logic       ent_rs, ent_rs_nx;
   logic [7:0] ent_data, ent_data_nx;
   logic       ent_last, ent_last_nx;
   logic       adv, adv_last;
   logic       go, go_rs;
   logic [7:0] go_data;
   logic       bus_idle, bus_last;
   logic [7:0] ctl;
   logic       unused_bits;

   assign ctl         = bus.Control_in;
   assign unused_bits = ^{bus.Address_in[7], ctl[4:1]};

   assign bus.sel_out = sel;
   assign bus.status  = {busy, done_sticky, 1'b0, sel};
   assign bus.lcd_rw  = 1'b0;

   lcd_bus_cycle #(
      .T_SETUP (T_SETUP),
      .T_PULSE (T_PULSE),
      .T_HOLD  (T_HOLD),
      .T_GAP   (T_GAP),
      .CNT_W   (CNT_W)
   ) u_bus (
      .clk      (clk),
      .reset    (reset),
      .go       (go),
      .go_rs    (go_rs),
      .go_data  (go_data),
      .lcd_e    (bus.lcd_e),
      .lcd_rs   (bus.lcd_rs),
      .lcd_data (bus.lcd_data),
      .idle     (bus_idle),
      .last     (bus_last)
   );

   // State and captured-entry registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         fetch_ph    <= 1'b0;
         launched    <= 1'b0;
         sel         <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         done_sticky <= 1'b0;
         addr_cmd    <= '0;
         ent_rs      <= 1'b0;
         ent_data    <= '0;
         ent_last    <= 1'b0;
      end else begin
         state       <= state_nx;
         fetch_ph    <= fetch_nx;
         launched    <= launched_nx;
         sel         <= sel_nx;
         busy        <= (state_nx != ST_IDLE);
         done        <= (state_nx == ST_DONE);
         done_sticky <= sticky_nx;
         addr_cmd    <= addr_nx;
         ent_rs      <= ent_rs_nx;
         ent_data    <= ent_data_nx;
         ent_last    <= ent_last_nx;
      end
   end

   // Fetch/decode/index sequencing. The data cycle of a set_addr entry is
   // launched in the address cycle's final GAP cycle so the two run back-to-back.
   always_comb begin
      state_nx    = state;
      fetch_nx    = fetch_ph;
      launched_nx = launched;
      sel_nx      = sel;
      sticky_nx   = done_sticky;
      addr_nx     = addr_cmd;
      ent_rs_nx   = ent_rs;
      ent_data_nx = ent_data;
      ent_last_nx = ent_last;
      adv         = 1'b0;
      adv_last    = ent_last;
      go          = 1'b0;
      go_rs       = ent_rs;
      go_data     = ent_data;
      case (state)
         ST_IDLE: if (start) begin
            state_nx  = ST_FETCH;
            fetch_nx  = 1'b0;
            sel_nx    = '0;
            sticky_nx = 1'b0;
         end
         ST_FETCH: begin
            if (!fetch_ph) begin
               fetch_nx = 1'b1;
            end else begin
               fetch_nx    = 1'b0;
               launched_nx = 1'b0;
               ent_rs_nx   = ctl[CTL_RS];
               ent_data_nx = bus.Data_in;
               ent_last_nx = ctl[CTL_LAST];
               addr_nx     = ddram_cmd(bus.Address_in[6:0]);
               if (!ctl[CTL_VALID]) begin
                  adv      = 1'b1;
                  adv_last = ctl[CTL_LAST];
               end else if (ctl[CTL_SET_ADDR]) begin
                  state_nx = ST_ADDR_CYC;
               end else begin
                  state_nx = ST_DATA_CYC;
               end
            end
         end
         ST_ADDR_CYC: begin
            if (!launched && bus_idle) begin
               go          = 1'b1;
               go_rs       = 1'b0;
               go_data     = addr_cmd;
               launched_nx = 1'b1;
            end else if (launched && bus_last) begin
               go       = 1'b1;
               state_nx = ST_DATA_CYC;
            end
         end
         ST_DATA_CYC: begin
            if (!launched && bus_idle) begin
               go          = 1'b1;
               launched_nx = 1'b1;
            end else if (launched && bus_last) begin
               adv = 1'b1;
            end
         end
         ST_DONE: begin
            state_nx = ST_IDLE;
            sel_nx   = '0;
         end
         default: state_nx = ST_IDLE;
      endcase
      if (adv) begin
         if (adv_last || (sel == '1)) begin
            state_nx  = ST_DONE;
            sticky_nx = 1'b1;
         end else begin
            sel_nx   = sel + 1'b1;
            state_nx = ST_FETCH;
            fetch_nx = 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_lcd_cmd_seq.sv
// Scoreboard bench for lcd_cmd_seq with a short bus timing (cycle = 7).
module tb_lcd_cmd_seq;

   localparam int unsigned TS = 1;
   localparam int unsigned TP = 2;
   localparam int unsigned TH = 1;
   localparam int unsigned TG = 3;

   logic clk = 1'b0;
   logic reset;
   logic start;
   logic busy;
   logic done;

   lcd_cmd_seq_if ifc();

   lcd_cmd_seq #(
      .T_SETUP (TS),
      .T_PULSE (TP),
      .T_HOLD  (TH),
      .T_GAP   (TG),
      .CNT_W   (8)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .busy  (busy),
      .done  (done),
      .bus   (ifc)
   );

   always #5 clk = ~clk;

   logic [31:0] cyc = '0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic        rs;
      logic [7:0]  data;
      logic [31:0] at;
   } strobe_t;

   strobe_t     exp_strobe[$];
   logic [31:0] exp_done[$];
   logic [4:0]  sel_log[$];
   int          checks = 0;
   int          failures = 0;
   int unsigned done_cnt = 0;

   logic [7:0] bank_a[32];
   logic [7:0] bank_c[32];
   logic [7:0] bank_d[32];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Register bank model: presents the selected entry half a cycle after sel_out moves.
   initial begin
      ifc.Address_in = '0;
      ifc.Control_in = '0;
      ifc.Data_in    = '0;
      forever begin
         @(negedge clk);
         ifc.Address_in = bank_a[ifc.sel_out];
         ifc.Control_in = bank_c[ifc.sel_out];
         ifc.Data_in    = bank_d[ifc.sel_out];
      end
   end

   // Monitor: pops expected strobes and done pulses as the DUT presents them.
   logic        mon_pe = 1'b0;
   logic        mon_pd = 1'b0;
   logic        mon_pb = 1'b0;
   logic [4:0]  mon_ps = '0;
   logic [31:0] rise_at = '0;
   initial begin
      strobe_t s;
      forever begin
         @(negedge clk);
         if (reset) begin
            mon_pe = 1'b0;
            mon_pd = 1'b0;
            mon_pb = 1'b0;
         end else begin
            if (ifc.lcd_e && !mon_pe) begin
               rise_at = cyc;
               if (exp_strobe.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_strobe at cycle %0d rs=%0b data=0x%0h", cyc, ifc.lcd_rs, ifc.lcd_data);
               end else begin
                  s = exp_strobe.pop_front();
                  check("strobe_cycle", cyc, s.at);
                  check("strobe_rs", 32'(ifc.lcd_rs), 32'(s.rs));
                  check("strobe_data", 32'(ifc.lcd_data), 32'(s.data));
                  check("lcd_rw", 32'(ifc.lcd_rw), 32'd0);
               end
            end
            if (!ifc.lcd_e && mon_pe) check("pulse_width", cyc - rise_at, TP);
            if (done && !mon_pd) begin
               done_cnt++;
               if (exp_done.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_done at cycle %0d", cyc);
               end else begin
                  check("done_cycle", cyc, exp_done.pop_front());
               end
               check("busy_at_done", 32'(busy), 32'd1);
            end
            if (mon_pd) begin
               check("done_width", 32'(done), 32'd0);
               check("busy_after_done", 32'(busy), 32'd0);
            end
            if (busy && (!mon_pb || ifc.sel_out != mon_ps)) sel_log.push_back(ifc.sel_out);
            mon_pe = ifc.lcd_e;
            mon_pd = done;
            mon_pb = busy;
            mon_ps = ifc.sel_out;
         end
      end
   end

   task automatic clear_bank();
      for (int i = 0; i < 32; i++) begin
         bank_a[i] = '0;
         bank_c[i] = '0;
         bank_d[i] = '0;
      end
   endtask

   // Expected strobes and done cycle for a walk whose start is sampled at edge n:
   // invalid entry 2 cycles, plain entry 10, set_addr entry 17.
   task automatic push_walk(input logic [31:0] n);
      logic [31:0] t;
      logic [7:0]  c;
      strobe_t     s;
      t = n;
      for (int i = 0; i < 32; i++) begin
         c = bank_c[i];
         if (!c[7]) begin
            t = t + 2;
         end else if (c[5]) begin
            s.rs = 1'b0; s.data = 8'h80 | {1'b0, bank_a[i][6:0]}; s.at = t + 4;
            exp_strobe.push_back(s);
            s.rs = c[0]; s.data = bank_d[i]; s.at = t + 11;
            exp_strobe.push_back(s);
            t = t + 17;
         end else begin
            s.rs = c[0]; s.data = bank_d[i]; s.at = t + 4;
            exp_strobe.push_back(s);
            t = t + 10;
         end
         if (c[6]) break;
      end
      exp_done.push_back(t);
   endtask

   task automatic issue_start();
      @(negedge clk);
      push_walk(cyc + 1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run_walk(input int unsigned extra_at);
      int unsigned target;
      int unsigned k;
      sel_log.delete();
      target = done_cnt + 1;
      issue_start();
      if (extra_at > 0) begin
         repeat (extra_at) @(negedge clk);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      k = 0;
      while (done_cnt < target && k < 2000) begin
         @(negedge clk);
         k++;
      end
      check("done_seen", 32'(done_cnt >= target), 32'd1);
      repeat (3) @(negedge clk);
      check("strobes_left", 32'(exp_strobe.size()), 32'd0);
      check("dones_left", 32'(exp_done.size()), 32'd0);
      check("status_after", 32'(ifc.status), 32'h40);
   endtask

   initial begin
      int unsigned k;
      reset = 1'b1;
      start = 1'b0;
      clear_bank();
      repeat (3) @(negedge clk);
      check("rst_sel", 32'(ifc.sel_out), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_status", 32'(ifc.status), 32'd0);
      check("rst_e", 32'(ifc.lcd_e), 32'd0);
      check("rst_rs", 32'(ifc.lcd_rs), 32'd0);
      check("rst_rw", 32'(ifc.lcd_rw), 32'd0);
      check("rst_data", 32'(ifc.lcd_data), 32'd0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // Single data entry.
      bank_a[0] = 8'h00; bank_c[0] = 8'hC1; bank_d[0] = 8'h41;
      run_walk(0);

      // set_addr entry: address command then data.
      clear_bank();
      bank_a[0] = 8'h45; bank_c[0] = 8'hE0; bank_d[0] = 8'h30;
      run_walk(0);

      // Skip of an invalid middle entry.
      clear_bank();
      bank_c[0] = 8'h80; bank_d[0] = 8'h12;
      bank_c[1] = 8'h00; bank_d[1] = 8'h99;
      bank_c[2] = 8'hC1; bank_d[2] = 8'h34;
      run_walk(0);
      check("sel_log_len", 32'(sel_log.size()), 32'd3);
      for (int i = 0; i < 3 && i < sel_log.size(); i++)
         check("sel_log_val", 32'(sel_log[i]), 32'(i));

      // Same list with a second start mid-walk.
      run_walk(15);
      check("sel_log_len_restart", 32'(sel_log.size()), 32'd3);

      // Full 32-entry walk, no last bit.
      clear_bank();
      for (int i = 0; i < 32; i++) begin
         bank_c[i] = 8'h81;
         bank_d[i] = 8'(i + 8'h20);
      end
      run_walk(0);
      check("full_log_len", 32'(sel_log.size()), 32'd32);
      if (sel_log.size() == 32) begin
         check("full_log_first", 32'(sel_log[0]), 32'd0);
         check("full_log_last", 32'(sel_log[31]), 32'd31);
      end

      // Reset during the E pulse, then replay from entry 0.
      clear_bank();
      bank_c[0] = 8'hC1; bank_d[0] = 8'h41;
      issue_start();
      k = 0;
      while (!ifc.lcd_e && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("e_seen_before_reset", 32'(ifc.lcd_e), 32'd1);
      #2 reset = 1'b1;
      @(negedge clk);
      #1;
      check("mid_rst_e", 32'(ifc.lcd_e), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_sel", 32'(ifc.sel_out), 32'd0);
      exp_strobe.delete();
      exp_done.delete();
      reset = 1'b0;
      repeat (2) @(negedge clk);
      run_walk(0);
      check("replay_log_first", 32'(sel_log.size() > 0 ? sel_log[0] : 5'h1f), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
